// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential digit-serial multiplier.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_W = 2;

endpackage

// File: rtl/multiplier.sv
// 2x2 unsigned digit multiplier built from two gated partial products.
module multiplier (
    input  logic [1:0] A,
    input  logic [1:0] B,
    output logic [3:0] P
);

    assign P = ({2'b00, A} & {4{B[0]}}) + ({1'b0, A, 1'b0} & {4{B[1]}});

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential unsigned multiplier: one 2x2 digit product per cycle, NDIG*NDIG
// cycles per operation, valid/ready handshakes on both sides.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW    = 2 * WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [IDX_W-1:0]   i_q, i_d, j_q, j_d;

    logic [DIGIT_W-1:0]   a_dig, b_dig;
    logic [2*DIGIT_W-1:0] dig_prod;
    logic [PW-1:0]        prod_ext;
    logic [IDX_W:0]       dig_pos;

    assign a_dig = a_q[{i_q, 1'b0} +: DIGIT_W];
    assign b_dig = b_q[{j_q, 1'b0} +: DIGIT_W];

    multiplier u_mult (
        .A (a_dig),
        .B (b_dig),
        .P (dig_prod)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        i_d      = i_q;
        j_d      = j_q;
        prod_ext = '0;
        prod_ext[2*DIGIT_W-1:0] = dig_prod;
        dig_pos  = {1'b0, i_q} + {1'b0, j_q};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Digit weight is 4^(i+j), i.e. a shift of 2*(i+j) bits.
                acc_d = acc_q + (prod_ext << {dig_pos, 1'b0});
                if (j_q == LAST_IDX) begin
                    j_d = '0;
                    if (i_q == LAST_IDX) begin
                        i_d     = '0;
                        state_d = DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    // Outputs decode straight from the state register, so reset clears them at once.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign p         = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Randomized self-checking bench for mult_seq_ctrl (WIDTH=8 and WIDTH=2 instances).
module tb_mult_seq_ctrl;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [15:0] p;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [1:0]  a2, b2;
    logic [3:0]  p2;

    int compared;
    int mismatched;

    mult_seq_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
    );

    mult_seq_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
        .out_valid(out_valid2), .out_ready(out_ready2), .p(p2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference latency for WIDTH=8: four digits per operand, one digit pair per cycle.
    localparam int LAT8 = (8 / 2) * (8 / 2);

    // Runs one WIDTH=8 operation; scrambles a/b after accept and optionally
    // pulses in_valid mid-run. Reports what was observed, checks nothing.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input int stall,
                       input bit pulse_iv,
                       output bit ready_before, output bit ready_in_run,
                       output int lat, output logic [15:0] pv,
                       output bit held_ok, output bit after_valid,
                       output bit after_ready, output logic [15:0] after_p);
        @(posedge clk); #1;
        ready_before = in_ready;
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        ready_in_run = in_ready;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (pulse_iv && lat == 3) begin
                in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        pv = p;
        held_ok = 1'b1;
        for (int k = 0; k < stall; k++) begin
            out_ready = (k % 2 == 0) ? 1'b0 : 1'b0;
            @(posedge clk); #1;
            if (p !== pv || out_valid !== 1'b1) held_ok = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        after_valid = out_valid;
        after_ready = in_ready;
        after_p = p;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; a = 0; b = 0;
        in_valid2 = 0; out_ready2 = 0; a2 = 0; b2 = 0;
        #12;
        compared++;
        if ({in_ready, out_valid, busy} !== 3'b100 || p !== 16'd0) begin
            mismatched++;
            $display("FAIL reset8: in_ready/out_valid/busy=%b%b%b p=%0d, required 100 p=0",
                     in_ready, out_valid, busy, p);
        end
        compared++;
        if ({in_ready2, out_valid2, busy2} !== 3'b100 || p2 !== 4'd0) begin
            mismatched++;
            $display("FAIL reset2: in_ready/out_valid/busy=%b%b%b p=%0d, required 100 p=0",
                     in_ready2, out_valid2, busy2, p2);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("reset released at %0t", $time);
    endtask

    task automatic check_op8(input string name, input logic [7:0] av, input logic [7:0] bv,
                             input int stall, input bit pulse_iv);
        bit rb, rr, held, av_after, ar_after;
        int lat;
        logic [15:0] pv, pa;
        logic [15:0] exp_p;
        exp_p = 16'(av) * 16'(bv);
        op8(av, bv, stall, pulse_iv, rb, rr, lat, pv, held, av_after, ar_after, pa);
        $display("%s: a=%0d b=%0d p=%0d lat=%0d", name, av, bv, pv, lat);
        compared++;
        if (pv !== exp_p) begin
            mismatched++;
            $display("FAIL %s product: got %0d, required %0d", name, pv, exp_p);
        end
        compared++;
        if (lat !== LAT8) begin
            mismatched++;
            $display("FAIL %s latency: got %0d, required %0d", name, lat, LAT8);
        end
        compared++;
        if (rb !== 1'b1 || rr !== 1'b0) begin
            mismatched++;
            $display("FAIL %s in_ready: idle=%b run=%b, required 1 and 0", name, rb, rr);
        end
        compared++;
        if (av_after !== 1'b0 || ar_after !== 1'b1 || pa !== 16'd0) begin
            mismatched++;
            $display("FAIL %s exit: out_valid=%b in_ready=%b p=%0d, required 0 1 0",
                     name, av_after, ar_after, pa);
        end
        if (stall > 0) begin
            compared++;
            if (held !== 1'b1) begin
                mismatched++;
                $display("FAIL %s hold: p/out_valid changed under backpressure, required stable %0d",
                         name, exp_p);
            end
        end
    endtask

    task automatic test_corners;
        check_op8("max", 8'd255, 8'd255, 0, 1'b0);
        check_op8("zero", 8'd0, 8'd173, 0, 1'b0);
        check_op8("three", 8'd3, 8'd3, 0, 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 8; n++)
            check_op8("rand", 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'b0);
    endtask

    task automatic test_backpressure;
        check_op8("stall5", 8'($urandom), 8'($urandom), 5, 1'b0);
    endtask

    task automatic test_ignore_in_valid;
        check_op8("ivpulse", 8'($urandom), 8'($urandom), 0, 1'b1);
    endtask

    task automatic test_reset_mid_run;
        bit saw_valid;
        @(posedge clk); #1;
        a = 8'd200; b = 8'd100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({in_ready, out_valid, busy} !== 3'b100 || p !== 16'd0) begin
            mismatched++;
            $display("FAIL midrun_reset: in_ready/out_valid/busy=%b%b%b p=%0d, required 100 p=0",
                     in_ready, out_valid, busy, p);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < LAT8 + 6; k++) begin
            @(posedge clk); #1;
            if (out_valid || busy) saw_valid = 1'b1;
        end
        $display("midrun_reset: aborted op, out_valid seen=%b", saw_valid);
        compared++;
        if (saw_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL midrun_abort: out_valid/busy seen=%b, required 0", saw_valid);
        end
        // First accept right after release must work.
        check_op8("post_reset", 8'($urandom), 8'($urandom), 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_p;
        out_ready2 = 1'b1;
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                exp_p = 4'(ai * bi);
                compared++;
                if (in_ready2 !== 1'b1) begin
                    mismatched++;
                    $display("FAIL w2_ready: in_ready=%b, required 1", in_ready2);
                end
                a2 = 2'(ai); b2 = 2'(bi); in_valid2 = 1'b1;
                @(posedge clk); #1;
                in_valid2 = 1'b0;
                a2 = 2'($urandom); b2 = 2'($urandom);
                @(posedge clk); #1;
                $display("w2: a=%0d b=%0d p=%0d out_valid=%b", ai, bi, p2, out_valid2);
                compared++;
                if (out_valid2 !== 1'b1 || p2 !== exp_p || in_ready2 !== 1'b0) begin
                    mismatched++;
                    $display("FAIL w2_product: out_valid=%b in_ready=%b p=%0d, required 1 0 %0d",
                             out_valid2, in_ready2, p2, exp_p);
                end
                @(posedge clk); #1;
                compared++;
                if (out_valid2 !== 1'b0 || p2 !== 4'd0) begin
                    mismatched++;
                    $display("FAIL w2_exit: out_valid=%b p=%0d, required 0 0", out_valid2, p2);
                end
            end
        end
        out_ready2 = 1'b0;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        test_reset();
        test_corners();
        test_random();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the operand width in bits; it must be an even number of at least 2.
REQ-002 The block SHALL derive constant NDIG = WIDTH/2, the number of 2-bit digits per operand.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset; asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands a/b are offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 The block SHALL have port a, input, WIDTH bits: unsigned multiplicand.
REQ-008 The block SHALL have port b, input, WIDTH bits: unsigned multiplier.
REQ-009 The block SHALL have port out_valid, output, 1 bit: product p is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts p.
REQ-011 The block SHALL have port p, output, 2*WIDTH bits: unsigned product a*b.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in every other state in_ready SHALL be 0.
REQ-015 An accept occurs on an edge where in_valid=1 and in_ready=1; on accept the block SHALL latch a and b, clear the accumulator, set digit indices i=0 and j=0, and enter RUN.
REQ-016 Each RUN cycle SHALL form the 4-bit product a[2i+1:2i]*b[2j+1:2j] on one shared 2x2 multiplier and add it, shifted left by 2*(i+j), into a 2*WIDTH-bit accumulator.
REQ-017 Index order SHALL be: j increments each RUN cycle; when j=NDIG-1, j wraps to 0 and i increments.
REQ-018 After the RUN cycle with i=j=NDIG-1, the FSM SHALL enter DONE with the final sum in p.
REQ-019 Latency SHALL be fixed: out_valid rises exactly NDIG*NDIG cycles after the accept edge (16 for WIDTH=8, 1 for WIDTH=2), with no data-dependent early exit.
REQ-020 In DONE, out_valid SHALL be 1 and p SHALL hold stable until an edge with out_ready=1; on that edge the FSM SHALL return to IDLE and drop out_valid.
REQ-021 out_ready SHALL be ignored when out_valid=0.
REQ-022 in_valid SHALL be ignored while busy=1; a/b changes during RUN or DONE SHALL NOT affect the result.
REQ-023 The accumulator SHALL NOT overflow, since the maximum value (2^WIDTH-1)^2 fits in 2*WIDTH bits.
REQ-024 Throughput SHALL be at most one operation per NDIG*NDIG+2 cycles; no new accept is possible on the DONE-exit edge.
REQ-025 p SHALL be 0 whenever out_valid=0.

Reset
REQ-026 Assertion of rst_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, busy=0, p=0, accumulator=0, and i=j=0.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation without producing any out_valid pulse.
REQ-028 After rst_n deasserts, the first accept SHALL be possible on the first rising edge of clk.

Structure
REQ-029 Package mult_seq_pkg SHALL hold the state enum (IDLE/RUN/DONE) and constant DIGIT_W=2.
REQ-030 The block SHALL instantiate exactly one sub-module, multiplier (ports A[1:0], B[1:0], P[3:0]), as the shared digit multiplier.
REQ-031 No other arithmetic multiply operator SHALL appear in the RTL.

Verification
REQ-032 With WIDTH=8, a=255 and b=255 -> out_valid rises 16 cycles after accept with p=65025.
REQ-033 With WIDTH=8, a=0 and b=173 -> p=0 after the full 16-cycle latency; with a=3 and b=3 -> p=9.
REQ-034 With WIDTH=2, all 16 (a,b) pairs back-to-back -> p matches a*b each time (for example 3*3=9 and 2*1=2), latency 1 cycle.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE -> p stays constant and out_valid stays 1; then out_ready=1 -> IDLE on the next edge.
REQ-036 Pulse in_valid with new operands during RUN -> ignored, and the original product is returned; pulse rst_n=0 mid-RUN -> outputs reset immediately and no out_valid appears.
